multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath: a Moore FSM that walks each instruction through fetch, decode, execute, memory and write-back, driving the shared ALU, single unified memory port, register file and PC muxes one step per cycle. It supports R-type, lw, sw, beq, bne, addi, andi and j. Unlike the single-cycle decoder, it stalls on a memory ready handshake, traps illegal opcodes and counts retired instructions. It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
- `COUNT_WIDTH`, 32, width of the retired-instruction counter.

- `clk` in 1: single clock, rising edge.
- `resetN` in 1: reset, synchronous, active-low.
- `opCode` in 6: IR[31:26], valid from DECODE onward.
- `memReady` in 1: memory completes the current read or write this cycle.
- `pcWrite` out 1: unconditional PC load.
- `pcWriteCondEq` out 1: PC load if ALU zero.
- `pcWriteCondNe` out 1: PC load if ALU not zero.
- `iorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read request.
- `memWrite` out 1: memory write request.
- `irWrite` out 1: latch IR.
- `memtoReg` out 1: register-file write data select, 1 = MDR.
- `regDst` out 1: register-file destination select, 1 = rd, 0 = rt.
- `regWrite` out 1: register-file write enable.
- `aluSrcA` out 1: ALU A select, 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU B select, 00 = register B, 01 = const 4, 10 = extended imm, 11 = sign-extended imm<<2.
- `extZero` out 1: immediate extension, 1 = zero-extend, 0 = sign-extend.
- `aluOp` out 2: 00 = add, 01 = sub, 10 = funct, 11 = and.
- `pcSource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `illegalOp` out 1: sticky trap flag.
- `instrDone` out 1: pulse on the final cycle of each instruction.
- `instrCount` out COUNT_WIDTH: retired-instruction count.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXE 6, RWB 7, BRANCH 8, IEXE 9, IWB 10, JUMP 11, TRAP 12.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite are asserted only when memReady=1.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Next state by opcode: 000000→REXE, 100011/101011→MEMADR, 000100/000101→BRANCH, 001000/001100→IEXE, 000010→JUMP, anything else→TRAP.
- MEMADR:
  - Outputs: aluSrcA=1, aluSrcB=10, extZero=0, aluOp=00.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: memRead=1, iorD=1.
  - Wait for memReady, then go to MEMWB.
- MEMWB:
  - Outputs: regWrite=1, memtoReg=1, regDst=0.
  - Done; next state FETCH.
- MEMWR:
  - Outputs: memWrite=1, iorD=1.
  - Wait for memReady; done on the memReady cycle, then FETCH.
- REXE:
  - Outputs: aluSrcA=1, aluSrcB=00, aluOp=10.
  - Next state RWB.
- RWB:
  - Outputs: regWrite=1, regDst=1, memtoReg=0.
  - Done; next state FETCH.
- BRANCH:
  - Outputs: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01.
  - pcWriteCondEq for opcode 000100; pcWriteCondNe for opcode 000101.
  - Done; next state FETCH.
- IEXE:
  - Outputs: aluSrcA=1, aluSrcB=10, aluOp=00 for addi, aluOp=11 with extZero=1 for andi.
  - Next state IWB.
- IWB:
  - Outputs: regWrite=1, regDst=0, memtoReg=0.
  - Done; next state FETCH.
- JUMP:
  - Outputs: pcWrite=1, pcSource=10.
  - Done; next state FETCH.
- TRAP:
  - illegalOp is set and held.
  - All control outputs are 0; the FSM stays in TRAP until reset.
  - No instrDone pulse for the illegal instruction.
- Outputs not listed for a state are 0.
- instrDone is asserted on the "done" cycle of each instruction. instrCount increments at the end of that cycle and wraps from all-ones to 0 without a flag.
- opCode is sampled only in DECODE and MEMADR/BRANCH/IEXE. Changes to opCode in other states are ignored.

## Timing
- Reset:
  - While resetN=0 at a clock edge: state←FETCH, illegalOp←0, instrCount←0.
  - While resetN is low, all control outputs and instrDone are forced to 0 combinationally.
  - Reset asserted mid-instruction (including mid-wait) aborts it with no count and no write.
- Minimum cycles with memReady held high:
  - lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3.
- Each FETCH, MEMRD or MEMWR cycle with memReady=0 adds one cycle. Request outputs stay stable during the wait.
- Outputs are Moore, except irWrite, pcWrite and instrDone in the wait states, which are gated by memReady in the same cycle.
- The first instruction fetch begins in the first cycle after resetN rises.

## Structure
- Shared package holds:
  - the 4-bit state encoding;
  - opcode constants (R-type, lw, sw, beq, bne, addi, andi, j);
  - aluOp, aluSrcB and pcSource encodings.
- Sub-module `multicycle_control_out`: purely combinational decode from (state, opCode, memReady) to control outputs.
- The top level holds the state register, the next-state logic, illegalOp and the counter.

## Test plan
- lw with memReady always 1: the state sequence is 0,1,2,3,4,0; one instrDone pulse, in state 4; instrCount goes 0→1; regWrite=1 only in MEMWB.
- sw with memReady low for 3 cycles in MEMWR: memWrite held 4 cycles, iorD=1 throughout, instrDone only on the memReady cycle; total 7 cycles.
- beq then bne back-to-back: pcWriteCondEq=1 only in the first BRANCH, pcWriteCondNe=1 only in the second; 3 cycles each; instrCount=2.
- andi opcode 001100: IEXE shows aluOp=11 and extZero=1; IWB shows regWrite=1 and regDst=0.
- Opcode 111111: DECODE→TRAP; illegalOp=1 is held for 20 cycles with all controls 0 and instrCount unchanged; resetN low for one edge clears illegalOp and returns to FETCH.
- With COUNT_WIDTH=4, run 16 j instructions: instrCount wraps 15→0. Asserting resetN=0 during a FETCH wait aborts with count 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// opcodes and the ALU / mux select codes driven onto the datapath.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXE   = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_out.sv
// Combinational control-word decode from (state, opcode, memory ready).
// Only the wait states look at mem_ready, so the request lines stay stable.
module multicycle_control_out
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond_eq,
    output logic       pc_write_cond_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_REG;
        ext_zero         = 1'b0;
        alu_op           = ALU_ADD;
        pc_source        = PCSRC_ALU;
        instr_done       = 1'b0;
        case (st)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALU_SUB;
                pc_source        = PCSRC_ALUOUT;
                pc_write_cond_eq = (op_code == OP_BEQ);
                pc_write_cond_ne = (op_code == OP_BNE);
                instr_done       = 1'b1;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (op_code == OP_ANDI) begin
                    alu_op   = ALU_AND;
                    ext_zero = 1'b1;
                end
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, sticky
// illegal-opcode trap and retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
)(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [5:0]             opCode,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   pcWriteCondEq,
    output logic                   pcWriteCondNe,
    output logic                   iorD,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   irWrite,
    output logic                   memtoReg,
    output logic                   regDst,
    output logic                   regWrite,
    output logic                   aluSrcA,
    output logic [1:0]             aluSrcB,
    output logic                   extZero,
    output logic [1:0]             aluOp,
    output logic [1:0]             pcSource,
    output logic                   illegalOp,
    output logic                   instrDone,
    output logic [COUNT_WIDTH-1:0] instrCount,
    output logic [3:0]             state
);

    state_t cur_state;
    state_t next_state;
    logic   illegal_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic       pc_write_c, cond_eq_c, cond_ne_c, iord_c, mem_read_c, mem_write_c;
    logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
    logic       ext_zero_c, instr_done_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cur_state <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            cur_state <= next_state;
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (instr_done_c) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH:  next_state = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:        next_state = S_REXE;
                    OP_LW, OP_SW:    next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:  next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI: next_state = S_IEXE;
                    OP_J:            next_state = S_JUMP;
                    default:         next_state = S_TRAP;
                endcase
            end
            // an opcode that changed under us after decode is treated as illegal
            S_MEMADR: begin
                if (opCode == OP_LW)      next_state = S_MEMRD;
                else if (opCode == OP_SW) next_state = S_MEMWR;
                else                      next_state = S_TRAP;
            end
            S_MEMRD:  next_state = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = memReady ? S_FETCH : S_MEMWR;
            S_REXE:   next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_IEXE:   next_state = S_IWB;
            S_IWB:    next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
    end

    multicycle_control_out u_out (
        .state            (cur_state),
        .op_code          (opCode),
        .mem_ready        (memReady),
        .pc_write         (pc_write_c),
        .pc_write_cond_eq (cond_eq_c),
        .pc_write_cond_ne (cond_ne_c),
        .iord             (iord_c),
        .mem_read         (mem_read_c),
        .mem_write        (mem_write_c),
        .ir_write         (ir_write_c),
        .mem_to_reg       (mem_to_reg_c),
        .reg_dst          (reg_dst_c),
        .reg_write        (reg_write_c),
        .alu_src_a        (alu_src_a_c),
        .alu_src_b        (alu_src_b_c),
        .ext_zero         (ext_zero_c),
        .alu_op           (alu_op_c),
        .pc_source        (pc_source_c),
        .instr_done       (instr_done_c)
    );

    // Controls are held quiet while reset is low so nothing is written mid-abort
    assign pcWrite       = resetN & pc_write_c;
    assign pcWriteCondEq = resetN & cond_eq_c;
    assign pcWriteCondNe = resetN & cond_ne_c;
    assign iorD          = resetN & iord_c;
    assign memRead       = resetN & mem_read_c;
    assign memWrite      = resetN & mem_write_c;
    assign irWrite       = resetN & ir_write_c;
    assign memtoReg      = resetN & mem_to_reg_c;
    assign regDst        = resetN & reg_dst_c;
    assign regWrite      = resetN & reg_write_c;
    assign aluSrcA       = resetN & alu_src_a_c;
    assign aluSrcB       = resetN ? alu_src_b_c : 2'b00;
    assign extZero       = resetN & ext_zero_c;
    assign aluOp         = resetN ? alu_op_c : 2'b00;
    assign pcSource      = resetN ? pc_source_c : 2'b00;
    assign instrDone     = resetN & instr_done_c;

    assign illegalOp  = illegal_q;
    assign instrCount = count_q;
    assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-word
// checks against hand-written expected words, plus counter/trap checks.
module tb_multicycle_control;

    logic       clk;
    logic       resetN;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite, pcWriteCondEq, pcWriteCondNe, iorD, memRead, memWrite;
    logic       irWrite, memtoReg, regDst, regWrite, aluSrcA, extZero;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       illegalOp, instrDone;
    logic [3:0] instrCount;
    logic [3:0] state;

    int n_pass = 0;
    int n_checks = 0;

    multicycle_control #(.COUNT_WIDTH(4)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .opCode        (opCode),
        .memReady      (memReady),
        .pcWrite       (pcWrite),
        .pcWriteCondEq (pcWriteCondEq),
        .pcWriteCondNe (pcWriteCondNe),
        .iorD          (iorD),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .irWrite       (irWrite),
        .memtoReg      (memtoReg),
        .regDst        (regDst),
        .regWrite      (regWrite),
        .aluSrcA       (aluSrcA),
        .aluSrcB       (aluSrcB),
        .extZero       (extZero),
        .aluOp         (aluOp),
        .pcSource      (pcSource),
        .illegalOp     (illegalOp),
        .instrDone     (instrDone),
        .instrCount    (instrCount),
        .state         (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // field order: pw ce cn iord mr mw ir m2r rd rw sa sb ez op ps done
    logic [18:0] ctrl;
    assign ctrl = {pcWrite, pcWriteCondEq, pcWriteCondNe, iorD, memRead, memWrite,
                   irWrite, memtoReg, regDst, regWrite, aluSrcA, aluSrcB, extZero,
                   aluOp, pcSource, instrDone};

    localparam logic [18:0] C_ZERO     = 19'b0_0_0_0_0_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [18:0] C_FETCH    = 19'b1_0_0_0_1_0_1_0_0_0_0_01_0_00_00_0;
    localparam logic [18:0] C_FETCH_W  = 19'b0_0_0_0_1_0_0_0_0_0_0_01_0_00_00_0;
    localparam logic [18:0] C_DECODE   = 19'b0_0_0_0_0_0_0_0_0_0_0_11_0_00_00_0;
    localparam logic [18:0] C_MEMADR   = 19'b0_0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [18:0] C_MEMRD    = 19'b0_0_0_1_1_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [18:0] C_MEMWB    = 19'b0_0_0_0_0_0_0_1_0_1_0_00_0_00_00_1;
    localparam logic [18:0] C_MEMWR_W  = 19'b0_0_0_1_0_1_0_0_0_0_0_00_0_00_00_0;
    localparam logic [18:0] C_MEMWR    = 19'b0_0_0_1_0_1_0_0_0_0_0_00_0_00_00_1;
    localparam logic [18:0] C_REXE     = 19'b0_0_0_0_0_0_0_0_0_0_1_00_0_10_00_0;
    localparam logic [18:0] C_RWB      = 19'b0_0_0_0_0_0_0_0_1_1_0_00_0_00_00_1;
    localparam logic [18:0] C_BEQ      = 19'b0_1_0_0_0_0_0_0_0_0_1_00_0_01_01_1;
    localparam logic [18:0] C_BNE      = 19'b0_0_1_0_0_0_0_0_0_0_1_00_0_01_01_1;
    localparam logic [18:0] C_IEXE_AND = 19'b0_0_0_0_0_0_0_0_0_0_1_10_1_11_00_0;
    localparam logic [18:0] C_IEXE_ADD = 19'b0_0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [18:0] C_IWB      = 19'b0_0_0_0_0_0_0_0_0_1_0_00_0_00_00_1;
    localparam logic [18:0] C_JUMP     = 19'b1_0_0_0_0_0_0_0_0_0_0_00_0_00_10_1;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BAD = 6'b111111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // driver: apply inputs for one cycle, check mid-cycle, advance past the edge
    task automatic cyc(input logic rdy, input logic [5:0] op, input logic [3:0] exp_st,
                       input logic [18:0] exp_ctrl, input string tag);
        memReady = rdy;
        opCode   = op;
        @(negedge clk);
        chk({tag, "_state"}, 32'(state), 32'(exp_st));
        chk({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        resetN = 1'b0;
        @(negedge clk);
        chk({tag, "_ctrl_in_reset"}, 32'(ctrl), 32'(C_ZERO));
        @(posedge clk);
        #1;
        resetN = 1'b1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_illegal"}, 32'(illegalOp), 32'd0);
        chk({tag, "_count"}, 32'(instrCount), 32'd0);
    endtask

    initial begin
        resetN   = 1'b0;
        memReady = 1'b1;
        opCode   = RT;
        @(posedge clk);
        #1;
        do_reset("por");

        // lw, no waits: 0,1,2,3,4
        cyc(1, LW, 4'd0, C_FETCH,  "lw_f");
        cyc(1, LW, 4'd1, C_DECODE, "lw_d");
        cyc(1, LW, 4'd2, C_MEMADR, "lw_ma");
        cyc(1, LW, 4'd3, C_MEMRD,  "lw_rd");
        cyc(1, LW, 4'd4, C_MEMWB,  "lw_wb");
        chk("lw_count", 32'(instrCount), 32'd1);

        // sw with three not-ready cycles in MEMWR
        cyc(1, SW, 4'd0, C_FETCH,   "sw_f");
        cyc(1, SW, 4'd1, C_DECODE,  "sw_d");
        cyc(1, SW, 4'd2, C_MEMADR,  "sw_ma");
        cyc(0, SW, 4'd5, C_MEMWR_W, "sw_w0");
        cyc(0, SW, 4'd5, C_MEMWR_W, "sw_w1");
        cyc(0, SW, 4'd5, C_MEMWR_W, "sw_w2");
        cyc(1, SW, 4'd5, C_MEMWR,   "sw_done");
        chk("sw_count", 32'(instrCount), 32'd2);

        // beq then bne back to back
        cyc(1, BEQ, 4'd0, C_FETCH,  "beq_f");
        cyc(1, BEQ, 4'd1, C_DECODE, "beq_d");
        cyc(1, BEQ, 4'd8, C_BEQ,    "beq_br");
        cyc(1, BNE, 4'd0, C_FETCH,  "bne_f");
        cyc(1, BNE, 4'd1, C_DECODE, "bne_d");
        cyc(1, BNE, 4'd8, C_BNE,    "bne_br");
        chk("br_count", 32'(instrCount), 32'd4);

        // andi
        cyc(1, ANDI, 4'd0,  C_FETCH,    "andi_f");
        cyc(1, ANDI, 4'd1,  C_DECODE,   "andi_d");
        cyc(1, ANDI, 4'd9,  C_IEXE_AND, "andi_ex");
        cyc(1, ANDI, 4'd10, C_IWB,      "andi_wb");

        // R-type with two fetch waits; opcode junk during fetch is ignored
        cyc(0, BAD, 4'd0, C_FETCH_W, "r_fw0");
        cyc(0, BAD, 4'd0, C_FETCH_W, "r_fw1");
        cyc(1, BAD, 4'd0, C_FETCH,   "r_f");
        cyc(1, RT,  4'd1, C_DECODE,  "r_d");
        cyc(1, RT,  4'd6, C_REXE,    "r_ex");
        cyc(1, RT,  4'd7, C_RWB,     "r_wb");

        // addi
        cyc(1, ADDI, 4'd0,  C_FETCH,    "addi_f");
        cyc(1, ADDI, 4'd1,  C_DECODE,   "addi_d");
        cyc(1, ADDI, 4'd9,  C_IEXE_ADD, "addi_ex");
        cyc(1, ADDI, 4'd10, C_IWB,      "addi_wb");
        chk("imm_r_count", 32'(instrCount), 32'd7);

        // illegal opcode: trap and hold
        cyc(1, BAD, 4'd0, C_FETCH,  "bad_f");
        cyc(1, BAD, 4'd1, C_DECODE, "bad_d");
        for (int i = 0; i < 20; i++) begin
            cyc(i[0], 6'(i * 7), 4'd12, C_ZERO, "trap");
            chk("trap_illegal", 32'(illegalOp), 32'd1);
            chk("trap_count", 32'(instrCount), 32'd7);
        end
        do_reset("trap_clr");

        // 16 jumps wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            cyc(1, J, 4'd0,  C_FETCH,  "j_f");
            cyc(1, J, 4'd1,  C_DECODE, "j_d");
            cyc(1, J, 4'd11, C_JUMP,   "j_j");
            if (i == 14) chk("j_count_15", 32'(instrCount), 32'd15);
        end
        chk("j_count_wrap", 32'(instrCount), 32'd0);

        // count one jump, then abort during a fetch wait
        cyc(1, J, 4'd0,  C_FETCH,  "j2_f");
        cyc(1, J, 4'd1,  C_DECODE, "j2_d");
        cyc(1, J, 4'd11, C_JUMP,   "j2_j");
        chk("j2_count", 32'(instrCount), 32'd1);
        cyc(0, J, 4'd0, C_FETCH_W, "abort_fw");
        memReady = 1'b0;
        do_reset("abort_fetch");

        // abort lw while waiting in MEMRD: no write, no count
        cyc(1, LW, 4'd0, C_FETCH,  "lwab_f");
        cyc(1, LW, 4'd1, C_DECODE, "lwab_d");
        cyc(1, LW, 4'd2, C_MEMADR, "lwab_ma");
        cyc(0, LW, 4'd3, C_MEMRD,  "lwab_rd");
        memReady = 1'b1;
        do_reset("abort_memrd");

        cyc(1, J, 4'd0,  C_FETCH,  "end_f");
        cyc(1, J, 4'd1,  C_DECODE, "end_d");
        cyc(1, J, 4'd11, C_JUMP,   "end_j");
        chk("end_count", 32'(instrCount), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
